// File: rtl/call_stack_pkg.sv
// Shared definitions for the return-address stack controller.
//   state_t        : controller states (NORMAL, ISR, FAULT)
//   ERR_*          : sticky error codes reported on err_code
//   IRQ_VEC_DEFAULT: default interrupt entry address
package call_stack_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        ISR    = 2'd1,
        FAULT  = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;
    localparam logic [1:0] ERR_RETI = 2'b11;

    localparam logic [9:0] IRQ_VEC_DEFAULT = 10'h3F0;

endpackage

// File: rtl/lifo_ram.sv
// Storage array for the return-address stack.
//   clk : write clock (rising edge)
//   we  : write enable
//   wa  : write address
//   wd  : write data
//   ra  : read address
//   rd  : asynchronous read data
// Contents are deliberately not reset.
module lifo_ram #(
    parameter int unsigned AW    = 10,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTRW  = 3
) (
    input  logic            clk,
    input  logic            we,
    input  logic [PTRW-1:0] wa,
    input  logic [AW-1:0]   wd,
    input  logic [PTRW-1:0] ra,
    output logic [AW-1:0]   rd
);

    logic [AW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd = mem[ra];

endmodule

// File: rtl/call_stack_ctrl.sv
// Clocked return-address stack controller: CALL/RET push/pop, single-level
// interrupt entry/exit, and fault detection with a halt request.
//   clk, reset      : clock, asynchronous active-high reset
//   call/ret/reti   : instruction ops this cycle
//   ret_addr        : address pushed by CALL (or replacing top on CALL+RET)
//   irq, pc_next    : interrupt request and resume address pushed on entry
//   top             : current top of stack, 0 when empty
//   irq_take        : interrupt accepted this cycle (combinational)
//   irq_vec         : interrupt entry address
//   count/full/empty: occupancy
//   in_isr          : inside the interrupt handler
//   err_code        : first error seen (sticky)
//   halt_req        : controller is in FAULT
module call_stack_ctrl
    import call_stack_pkg::*;
#(
    parameter int unsigned    AW      = 10,
    parameter int unsigned    DEPTH   = 8,
    parameter int unsigned    PTRW    = 3,
    parameter logic [AW-1:0]  IRQ_VEC = AW'(IRQ_VEC_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            call,
    input  logic            ret,
    input  logic            reti,
    input  logic [AW-1:0]   ret_addr,
    input  logic            irq,
    input  logic [AW-1:0]   pc_next,
    output logic [AW-1:0]   top,
    output logic            irq_take,
    output logic [AW-1:0]   irq_vec,
    output logic [PTRW:0]   count,
    output logic            full,
    output logic            empty,
    output logic            in_isr,
    output logic [1:0]      err_code,
    output logic            halt_req
);

    localparam logic [PTRW:0] CNT_ONE  = (PTRW+1)'(1);
    localparam logic [PTRW:0] CNT_FULL = (PTRW+1)'(DEPTH);

    state_t          state;
    logic [PTRW:0]   isr_base;
    logic [PTRW:0]   cnt_inc;
    logic [PTRW:0]   cnt_dec;
    logic [PTRW:0]   isr_base_inc;
    logic [1:0]      err_det;
    logic            do_push;
    logic            do_pop;
    logic            do_repl;
    logic            do_leave;
    logic            we;
    logic [PTRW-1:0] wa;
    logic [AW-1:0]   wd;
    logic [AW-1:0]   rd;

    assign cnt_inc      = count + CNT_ONE;
    assign cnt_dec      = count - CNT_ONE;
    assign isr_base_inc = isr_base + CNT_ONE;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign in_isr   = (state == ISR);
    assign halt_req = (state == FAULT);
    assign irq_vec  = IRQ_VEC;

    // Any instruction op blocks the interrupt; it is retried next cycle.
    assign irq_take = (state == NORMAL) & irq & ~call & ~ret & ~reti & ~full;

    // Decode this cycle's instruction op into an action or an error.
    always_comb begin
        err_det  = ERR_NONE;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        do_repl  = 1'b0;
        do_leave = 1'b0;
        if (state != FAULT) begin
            if (reti && (call || ret)) begin
                err_det = ERR_RETI;
            end else if (call && ret) begin
                if (empty) err_det = ERR_UNF;
                else       do_repl = 1'b1;
            end else if (call) begin
                if (full) err_det = ERR_OVF;
                else      do_push = 1'b1;
            end else if (ret) begin
                if (empty) err_det = ERR_UNF;
                else       do_pop  = 1'b1;
            end else if (reti) begin
                // Only the frame pushed at interrupt entry may remain.
                if (state == ISR && count == isr_base_inc) begin
                    do_pop   = 1'b1;
                    do_leave = 1'b1;
                end else begin
                    err_det = ERR_RETI;
                end
            end
        end
    end

    assign we = do_push | do_repl | irq_take;
    assign wa = do_repl ? cnt_dec[PTRW-1:0] : count[PTRW-1:0];
    assign wd = irq_take ? pc_next : ret_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= NORMAL;
            count    <= '0;
            isr_base <= '0;
            err_code <= ERR_NONE;
        end else if (state != FAULT) begin
            if (err_det != ERR_NONE) begin
                state <= FAULT;
                if (err_code == ERR_NONE) begin
                    err_code <= err_det;
                end
            end else if (irq_take) begin
                count    <= cnt_inc;
                isr_base <= count;
                state    <= ISR;
            end else if (do_push) begin
                count <= cnt_inc;
            end else if (do_pop) begin
                count <= cnt_dec;
                if (do_leave) begin
                    state <= NORMAL;
                end
            end
        end
    end

    lifo_ram #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .PTRW  (PTRW)
    ) u_ram (
        .clk (clk),
        .we  (we),
        .wa  (wa),
        .wd  (wd),
        .ra  (cnt_dec[PTRW-1:0]),
        .rd  (rd)
    );

    assign top = empty ? '0 : rd;

endmodule

// File: tb/tb_call_stack_ctrl.sv
module tb_call_stack_ctrl;

    localparam int AW    = 10;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          call = 1'b0, ret = 1'b0, reti = 1'b0, irq = 1'b0;
    logic [AW-1:0] ret_addr = '0, pc_next = '0;
    logic [AW-1:0] top, irq_vec;
    logic          irq_take, full, empty, in_isr, halt_req;
    logic [3:0]    count;
    logic [1:0]    err_code;

    call_stack_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .call     (call),
        .ret      (ret),
        .reti     (reti),
        .ret_addr (ret_addr),
        .irq      (irq),
        .pc_next  (pc_next),
        .top      (top),
        .irq_take (irq_take),
        .irq_vec  (irq_vec),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .in_isr   (in_isr),
        .err_code (err_code),
        .halt_req (halt_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        int take;
        int top;
        int count;
        int full;
        int empty;
        int in_isr;
        int err;
        int halt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: stack as a queue, mode 0=normal 1=isr 2=fault.
    logic [AW-1:0] stk[$];
    int            mode = 0;
    int            isr_base = 0;
    int            err = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t snapshot(input int take);
        exp_t e;
        e.take   = take;
        e.count  = stk.size();
        e.top    = (stk.size() == 0) ? 0 : int'(stk[stk.size()-1]);
        e.full   = (stk.size() == DEPTH) ? 1 : 0;
        e.empty  = (stk.size() == 0) ? 1 : 0;
        e.in_isr = (mode == 1) ? 1 : 0;
        e.err    = err;
        e.halt   = (mode == 2) ? 1 : 0;
        return e;
    endfunction

    task automatic model_reset();
        stk.delete();
        mode = 0;
        isr_base = 0;
        err = 0;
    endtask

    // One instruction cycle: drive, log expectation, advance the model.
    task automatic cyc(input bit c, input bit r, input bit ri, input logic [AW-1:0] a,
                       input bit i, input logic [AW-1:0] pn);
        int take;
        int e;
        @(posedge clk);
        #1;
        call = c; ret = r; reti = ri; ret_addr = a; irq = i; pc_next = pn;
        take = (mode == 0 && i && !c && !r && !ri && stk.size() < DEPTH) ? 1 : 0;
        sb.push_back(snapshot(take));
        if (mode != 2) begin
            e = 0;
            if (ri && (c || r)) e = 3;
            else if (c && r) begin
                if (stk.size() == 0) e = 2;
                else stk[stk.size()-1] = a;
            end else if (c) begin
                if (stk.size() == DEPTH) e = 1;
                else stk.push_back(a);
            end else if (r) begin
                if (stk.size() == 0) e = 2;
                else void'(stk.pop_back());
            end else if (ri) begin
                if (mode == 1 && stk.size() == isr_base + 1) begin
                    void'(stk.pop_back());
                    mode = 0;
                end else e = 3;
            end else if (take == 1) begin
                isr_base = stk.size();
                stk.push_back(pn);
                mode = 1;
            end
            if (e != 0) begin
                mode = 2;
                if (err == 0) err = e;
            end
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, '0, 0, '0);
    endtask

    // Reset pulse between edges; effect must be visible before any clock edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        call = 0; ret = 0; reti = 0; irq = 0;
        reset = 1'b1;
        #2;
        chk("rst_count", int'(count), 0);
        chk("rst_err", int'(err_code), 0);
        chk("rst_in_isr", int'(in_isr), 0);
        chk("rst_halt", int'(halt_req), 0);
        chk("rst_top", int'(top), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_irq_take", int'(irq_take), 0);
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("irq_take", int'(irq_take), e.take);
                chk("top", int'(top), e.top);
                chk("count", int'(count), e.count);
                chk("full", int'(full), e.full);
                chk("empty", int'(empty), e.empty);
                chk("in_isr", int'(in_isr), e.in_isr);
                chk("err_code", int'(err_code), e.err);
                chk("halt_req", int'(halt_req), e.halt);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        reset = 1'b0;
        do_reset();
        chk("irq_vec", int'(irq_vec), 'h3F0);

        // Pushes and pops
        cyc(1, 0, 0, 10'h005, 0, '0);
        cyc(1, 0, 0, 10'h012, 0, '0);
        cyc(1, 0, 0, 10'h020, 0, '0);
        repeat (3) cyc(0, 1, 0, '0, 0, '0);
        idle();

        // Overflow, then a frozen ret
        do_reset();
        for (int k = 1; k <= 8; k++) cyc(1, 0, 0, AW'(k), 0, '0);
        cyc(1, 0, 0, 10'h3FF, 0, '0);
        cyc(0, 1, 0, '0, 0, '0);
        idle();

        // Underflow
        do_reset();
        cyc(0, 1, 0, '0, 0, '0);
        idle();

        // Interrupt round trip
        do_reset();
        cyc(1, 0, 0, 10'h005, 0, '0);
        cyc(0, 0, 0, '0, 1, 10'h044);
        cyc(1, 0, 0, 10'h3F3, 1, 10'h050);
        cyc(0, 1, 0, '0, 1, 10'h051);
        cyc(0, 0, 1, '0, 0, '0);
        idle();

        // Priority then bad RETI
        do_reset();
        cyc(1, 0, 0, 10'h010, 1, 10'h060);
        cyc(0, 0, 0, '0, 1, 10'h061);
        cyc(1, 0, 0, 10'h3F5, 0, '0);
        cyc(0, 0, 1, '0, 0, '0);
        idle();

        // Replace and illegal combinations
        do_reset();
        cyc(1, 1, 0, 10'h111, 0, '0);
        idle();
        do_reset();
        cyc(1, 0, 0, 10'h0AA, 0, '0);
        cyc(1, 1, 0, 10'h0BB, 0, '0);
        cyc(0, 1, 1, '0, 0, '0);
        idle();

        // FAULT with count 5, then async reset
        do_reset();
        for (int k = 0; k < 5; k++) cyc(1, 0, 0, AW'(10'h100 + k), 0, '0);
        cyc(0, 0, 1, '0, 0, '0);
        idle();
        do_reset();
        idle();

        // Randomized bursts
        for (int b = 0; b < 25; b++) begin
            do_reset();
            for (int n = 0; n < 40; n++) begin
                int r;
                bit c, rt, ri, i;
                r  = $urandom_range(99);
                c  = (r < 38) || (r >= 90 && r < 93) || r == 99;
                rt = (r >= 38 && r < 62) || (r >= 90 && r < 93);
                ri = (r >= 62 && r < 70) || r == 99;
                i  = ($urandom_range(99) < 35);
                cyc(c, rt, ri, AW'($urandom), i, AW'($urandom));
            end
            idle();
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
